// File: rtl/reward_spawner_pkg.sv
// Shared types and helpers for the reward spawner: FSM states, reward codes,
// LFSR step and draw decoding.
package reward_spawner_pkg;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned TRY_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_PLACE,
    ST_SHOW
  } state_t;

  typedef enum logic [2:0] {
    REWARD_NONE    = 3'd0,
    REWARD_PROTECT = 3'd1,
    REWARD_FASTER  = 3'd2,
    REWARD_FROZEN  = 3'd3,
    REWARD_LASER   = 3'd4
  } reward_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Two LFSR bits select one of the four real reward kinds (1..4).
  function automatic logic [2:0] draw_type(input logic [15:0] l);
    return {1'b0, l[11:10]} + 3'd1;
  endfunction

  function automatic logic same_cell(input logic [4:0] ax, input logic [4:0] ay,
                                     input logic [4:0] bx, input logic [4:0] by);
    return (ax == bx) && (ay == by);
  endfunction

endpackage

// File: rtl/reward_spawner_if.sv
// Game-side bundle of the reward spawner: mode/frame/tank inputs and the
// reward placement and pickup outputs.
interface reward_spawner_if;
  logic       enable_game_classic;
  logic       enable_game_infinity;
  logic       frame_tick;
  logic [4:0] tank1_xpos;
  logic [4:0] tank1_ypos;
  logic [4:0] tank2_xpos;
  logic [4:0] tank2_ypos;
  logic       set_require;
  logic [4:0] random_xpos;
  logic [4:0] random_ypos;
  logic [2:0] reward_type;
  logic       reward_got;
  logic       reward_got_player;
  logic [2:0] reward_got_type;

  modport master (
    output enable_game_classic, enable_game_infinity, frame_tick,
           tank1_xpos, tank1_ypos, tank2_xpos, tank2_ypos,
    input  set_require, random_xpos, random_ypos, reward_type,
           reward_got, reward_got_player, reward_got_type
  );

  modport slave (
    input  enable_game_classic, enable_game_infinity, frame_tick,
           tank1_xpos, tank1_ypos, tank2_xpos, tank2_ypos,
    output set_require, random_xpos, random_ypos, reward_type,
           reward_got, reward_got_player, reward_got_type
  );
endinterface

// File: rtl/reward_spawner_lfsr.sv
// Free-running 16-bit Fibonacci LFSR used as the placement random source.
module reward_lfsr
  import reward_spawner_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] o_lfsr
);

  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lfsr <= SEED;
    else        r_lfsr <= lfsr_next(r_lfsr);
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/reward_spawner.sv
// Reward spawner: waits SPAWN_FRAMES, places a power-up on a free cell, shows it
// for LIFE_FRAMES and reports which tank picked it up.
module reward_spawner
  import reward_spawner_pkg::*;
#(
  parameter int unsigned GRID_W       = 20,
  parameter int unsigned GRID_H       = 20,
  parameter int unsigned SPAWN_FRAMES = 300,
  parameter int unsigned LIFE_FRAMES  = 600,
  parameter int unsigned MAX_TRY      = 31,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  reward_spawner_if.slave  bus
);

  localparam logic [5:0]       GW       = 6'(GRID_W);
  localparam logic [5:0]       GH       = 6'(GRID_H);
  localparam logic [4:0]       FB_X     = 5'(GRID_W - 1);
  localparam logic [4:0]       FB_Y     = 5'(GRID_H - 1);
  localparam logic [CNT_W-1:0] SPAWN_LD = CNT_W'(SPAWN_FRAMES);
  localparam logic [CNT_W-1:0] LIFE_LD  = CNT_W'(LIFE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRY);
  localparam logic [TRY_W-1:0] TRY_ONE  = TRY_W'(1);

  state_t           r_state, w_state_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic [TRY_W-1:0] r_try, w_try_n;
  logic             r_set, w_set_n;
  logic [4:0]       r_x, w_x_n;
  logic [4:0]       r_y, w_y_n;
  logic [2:0]       r_type, w_type_n;
  logic             r_got, w_got_n;
  logic             r_player, w_player_n;
  logic [2:0]       r_gtype, w_gtype_n;

  logic [15:0] w_lfsr;
  logic [3:0]  w_unused_lfsr;
  logic [4:0]  w_dx, w_dy;
  logic [2:0]  w_dt;
  logic        w_game_on, w_draw_hit, w_draw_ok, w_fb_hit;
  logic        w_pick1, w_pick2, w_cnt_last, w_try_last;

  reward_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_lfsr (w_lfsr)
  );

  assign w_unused_lfsr = w_lfsr[15:12];
  assign w_dx          = w_lfsr[4:0];
  assign w_dy          = w_lfsr[9:5];
  assign w_dt          = draw_type(w_lfsr);
  assign w_game_on     = bus.enable_game_classic | bus.enable_game_infinity;

  assign w_draw_hit = same_cell(w_dx, w_dy, bus.tank1_xpos, bus.tank1_ypos) |
                      same_cell(w_dx, w_dy, bus.tank2_xpos, bus.tank2_ypos);
  assign w_draw_ok  = ({1'b0, w_dx} < GW) && ({1'b0, w_dy} < GH) && !w_draw_hit;
  assign w_fb_hit   = same_cell(FB_X, FB_Y, bus.tank1_xpos, bus.tank1_ypos) |
                      same_cell(FB_X, FB_Y, bus.tank2_xpos, bus.tank2_ypos);
  assign w_pick1    = same_cell(r_x, r_y, bus.tank1_xpos, bus.tank1_ypos);
  assign w_pick2    = same_cell(r_x, r_y, bus.tank2_xpos, bus.tank2_ypos);
  assign w_cnt_last = (r_cnt <= CNT_ONE);
  assign w_try_last = (r_try == TRY_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_try    <= '0;
      r_set    <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_type   <= '0;
      r_got    <= 1'b0;
      r_player <= 1'b0;
      r_gtype  <= '0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_try    <= w_try_n;
      r_set    <= w_set_n;
      r_x      <= w_x_n;
      r_y      <= w_y_n;
      r_type   <= w_type_n;
      r_got    <= w_got_n;
      r_player <= w_player_n;
      r_gtype  <= w_gtype_n;
    end
  end

  // Outputs are registered alongside the state, so a transition and its
  // visible effect (show, pickup pulse, retire) appear on the same edge.
  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_try_n    = r_try;
    w_set_n    = r_set;
    w_x_n      = r_x;
    w_y_n      = r_y;
    w_type_n   = r_type;
    w_got_n    = 1'b0;
    w_player_n = r_player;
    w_gtype_n  = r_gtype;
    if (!w_game_on) begin
      w_state_n = ST_IDLE;
      w_set_n   = 1'b0;
      w_x_n     = '0;
      w_y_n     = '0;
      w_type_n  = REWARD_NONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_n = ST_WAIT;
          w_cnt_n   = SPAWN_LD;
        end
        ST_WAIT: begin
          if (bus.frame_tick) begin
            if (w_cnt_last) begin
              w_state_n = ST_PLACE;
              w_cnt_n   = '0;
              w_try_n   = '0;
            end else begin
              w_cnt_n = r_cnt - CNT_ONE;
            end
          end
        end
        ST_PLACE: begin
          if (w_try_last || w_draw_ok) begin
            w_state_n = ST_SHOW;
            w_cnt_n   = LIFE_LD;
            w_set_n   = 1'b1;
            w_type_n  = w_dt;
            if (w_try_last) begin
              w_x_n = w_fb_hit ? 5'd0 : FB_X;
              w_y_n = w_fb_hit ? 5'd0 : FB_Y;
            end else begin
              w_x_n = w_dx;
              w_y_n = w_dy;
            end
          end else begin
            w_try_n = r_try + TRY_ONE;
          end
        end
        ST_SHOW: begin
          // Pickup outranks expiry; tank1 outranks tank2.
          if (w_pick1 || w_pick2) begin
            w_got_n    = 1'b1;
            w_player_n = ~w_pick1;
            w_gtype_n  = r_type;
            w_set_n    = 1'b0;
            w_type_n   = REWARD_NONE;
            w_state_n  = ST_WAIT;
            w_cnt_n    = SPAWN_LD;
          end else if (bus.frame_tick) begin
            if (w_cnt_last) begin
              w_set_n   = 1'b0;
              w_type_n  = REWARD_NONE;
              w_state_n = ST_WAIT;
              w_cnt_n   = SPAWN_LD;
            end else begin
              w_cnt_n = r_cnt - CNT_ONE;
            end
          end
        end
        default: w_state_n = ST_IDLE;
      endcase
    end
  end

  assign bus.set_require       = r_set;
  assign bus.random_xpos       = r_x;
  assign bus.random_ypos       = r_y;
  assign bus.reward_type       = r_type;
  assign bus.reward_got        = r_got;
  assign bus.reward_got_player = r_player;
  assign bus.reward_got_type   = r_gtype;

endmodule

// File: tb/tb_reward_spawner.sv
// Scoreboard bench for reward_spawner: a procedural reference model pushes expected
// place/pickup/retire events; monitors pop and compare them as the DUTs emit them.
module tb_reward_spawner;

  logic        clk;
  logic        rst_n;
  int unsigned cyc;
  int          vectors;
  int          miscompares;

  reward_spawner_if b0();
  reward_spawner_if b1();

  // d0: 20x20 grid, short timers, few tries so fallback placement is common.
  reward_spawner #(
    .GRID_W(20), .GRID_H(20), .SPAWN_FRAMES(3), .LIFE_FRAMES(2),
    .MAX_TRY(3), .LFSR_SEED(16'hACE1)
  ) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

  // d1: 1x1 grid with tank1 parked on the only cell.
  reward_spawner #(
    .GRID_W(1), .GRID_H(1), .SPAWN_FRAMES(2), .LIFE_FRAMES(3),
    .MAX_TRY(31), .LFSR_SEED(16'hACE1)
  ) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  typedef enum int {EV_PLACE, EV_GOT, EV_RETIRE} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int unsigned cyc;
    int          x;
    int          y;
    int          t;
    int          player;
  } ev_t;
  typedef struct {
    logic        on;
    logic        tick;
    int          t1x, t1y, t2x, t2y;
    int          l;
    int unsigned cyc;
  } smp_t;
  typedef struct {
    logic       sr, got, pl;
    logic [4:0] x, y;
    logic [2:0] t, gt;
  } out_t;

  ev_t q0[$];
  ev_t q1[$];
  logic [15:0] m_l;

  initial begin
    clk = 1'b0;
    cyc = 0;
    forever begin
      #5;
      cyc = cyc + 1;
      clk = 1'b1;
      #5;
      clk = 1'b0;
    end
  end

  // Golden LFSR sequence, straight from the feedback polynomial.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_l <= 16'hACE1;
    else        m_l <= 16'((m_l << 1) | 16'(m_l[15] ^ m_l[13] ^ m_l[12] ^ m_l[10]));
  end

  function automatic int p_gw(input int id);    return (id == 0) ? 20 : 1; endfunction
  function automatic int p_gh(input int id);    return (id == 0) ? 20 : 1; endfunction
  function automatic int p_spawn(input int id); return (id == 0) ? 3 : 2;  endfunction
  function automatic int p_life(input int id);  return (id == 0) ? 2 : 3;  endfunction
  function automatic int p_maxt(input int id);  return (id == 0) ? 3 : 31; endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int id, input ev_t e);
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  function automatic bit pop(input int id, output ev_t e);
    if (id == 0) begin
      if (q0.size() == 0) return 1'b0;
      e = q0.pop_front();
    end else begin
      if (q1.size() == 0) return 1'b0;
      e = q1.pop_front();
    end
    return 1'b1;
  endfunction

  function automatic out_t get_out(input int id);
    out_t o;
    if (id == 0) begin
      o.sr = b0.set_require; o.got = b0.reward_got; o.pl = b0.reward_got_player;
      o.x = b0.random_xpos;  o.y = b0.random_ypos;  o.t = b0.reward_type;
      o.gt = b0.reward_got_type;
    end else begin
      o.sr = b1.set_require; o.got = b1.reward_got; o.pl = b1.reward_got_player;
      o.x = b1.random_xpos;  o.y = b1.random_ypos;  o.t = b1.reward_type;
      o.gt = b1.reward_got_type;
    end
    return o;
  endfunction

  task automatic step(input int id, output smp_t s);
    @(posedge clk);
    s.l   = int'(m_l);
    s.cyc = cyc;
    if (id == 0) begin
      s.on  = rst_n && (b0.enable_game_classic || b0.enable_game_infinity);
      s.tick = b0.frame_tick;
      s.t1x = int'(b0.tank1_xpos); s.t1y = int'(b0.tank1_ypos);
      s.t2x = int'(b0.tank2_xpos); s.t2y = int'(b0.tank2_ypos);
    end else begin
      s.on  = rst_n && (b1.enable_game_classic || b1.enable_game_infinity);
      s.tick = b1.frame_tick;
      s.t1x = int'(b1.tank1_xpos); s.t1y = int'(b1.tank1_ypos);
      s.t2x = int'(b1.tank2_xpos); s.t2y = int'(b1.tank2_ypos);
    end
  endtask

  function automatic bit on_tank(input smp_t s, input int x, input int y);
    return (x == s.t1x && y == s.t1y) || (x == s.t2x && y == s.t2y);
  endfunction

  // Reference model: one game session as a sequence of timed phases.
  task automatic model(input int id);
    smp_t s;
    ev_t  e;
    int   remaining, tries, x, y, t;
    bit   abort, placed, done;
    forever begin
      do step(id, s); while (!s.on);
      abort = 1'b0;
      while (!abort) begin
        remaining = p_spawn(id);
        while (!abort && remaining > 0) begin
          step(id, s);
          if (!s.on) abort = 1'b1;
          else if (s.tick) remaining--;
        end
        if (abort) break;
        tries = 0; placed = 1'b0; x = 0; y = 0; t = 0;
        while (!abort && !placed) begin
          step(id, s);
          if (!s.on) abort = 1'b1;
          else begin
            x = s.l % 32;
            y = (s.l / 32) % 32;
            t = (s.l / 1024) % 4 + 1;
            if (tries == p_maxt(id)) begin
              x = p_gw(id) - 1;
              y = p_gh(id) - 1;
              if (on_tank(s, x, y)) begin x = 0; y = 0; end
              placed = 1'b1;
            end else if (x < p_gw(id) && y < p_gh(id) && !on_tank(s, x, y)) placed = 1'b1;
            else tries++;
          end
        end
        if (abort) break;
        e.kind = EV_PLACE; e.cyc = s.cyc; e.x = x; e.y = y; e.t = t; e.player = 0;
        push(id, e);
        remaining = p_life(id);
        done = 1'b0;
        while (!done) begin
          step(id, s);
          e.cyc = s.cyc;
          if (!s.on) begin
            e.kind = EV_RETIRE; push(id, e); abort = 1'b1; done = 1'b1;
          end else if (x == s.t1x && y == s.t1y) begin
            e.kind = EV_GOT; e.player = 0; push(id, e); done = 1'b1;
          end else if (x == s.t2x && y == s.t2y) begin
            e.kind = EV_GOT; e.player = 1; push(id, e); done = 1'b1;
          end else if (s.tick) begin
            remaining--;
            if (remaining == 0) begin e.kind = EV_RETIRE; push(id, e); done = 1'b1; end
          end
        end
      end
    end
  endtask

  task automatic monitor(input int id);
    out_t  o;
    ev_t   e, cur;
    logic  prev_sr;
    bit    ok;
    string d;
    d = $sformatf("d%0d", id);
    prev_sr = 1'b0;
    cur.x = 0; cur.y = 0; cur.t = 0;
    forever begin
      @(posedge clk);
      #1;
      o = get_out(id);
      if (o.got) begin
        ok = pop(id, e);
        chk({d, " got.expected"}, 32'(ok), 1);
        if (ok) begin
          chk({d, " got.kind"}, 32'(e.kind), 32'(EV_GOT));
          chk({d, " got.cycle"}, e.cyc, cyc);
          chk({d, " got.player"}, 32'(o.pl), 32'(e.player));
          chk({d, " got.type"}, 32'(o.gt), 32'(e.t));
          chk({d, " got.set_require"}, 32'(o.sr), 0);
          chk({d, " got.reward_type"}, 32'(o.t), 0);
        end
      end else if (prev_sr && !o.sr) begin
        ok = pop(id, e);
        chk({d, " retire.expected"}, 32'(ok), 1);
        if (ok) begin
          chk({d, " retire.kind"}, 32'(e.kind), 32'(EV_RETIRE));
          chk({d, " retire.cycle"}, e.cyc, cyc);
        end
      end
      if (!prev_sr && o.sr) begin
        ok = pop(id, e);
        chk({d, " place.expected"}, 32'(ok), 1);
        if (ok) begin
          cur = e;
          chk({d, " place.kind"}, 32'(e.kind), 32'(EV_PLACE));
          chk({d, " place.cycle"}, e.cyc, cyc);
          chk({d, " place.x"}, 32'(o.x), 32'(e.x));
          chk({d, " place.y"}, 32'(o.y), 32'(e.y));
          chk({d, " place.type"}, 32'(o.t), 32'(e.t));
        end
      end else if (o.sr) begin
        chk({d, " show.x"}, 32'(o.x), 32'(cur.x));
        chk({d, " show.y"}, 32'(o.y), 32'(cur.y));
        chk({d, " show.type"}, 32'(o.t), 32'(cur.t));
      end
      prev_sr = o.sr;
    end
  endtask

  initial model(0);
  initial model(1);
  initial monitor(0);
  initial monitor(1);

  task automatic check_zero(input string tag);
    chk({tag, " set_require"}, 32'(b0.set_require), 0);
    chk({tag, " random_xpos"}, 32'(b0.random_xpos), 0);
    chk({tag, " random_ypos"}, 32'(b0.random_ypos), 0);
    chk({tag, " reward_type"}, 32'(b0.reward_type), 0);
    chk({tag, " reward_got"}, 32'(b0.reward_got), 0);
    chk({tag, " got_player"}, 32'(b0.reward_got_player), 0);
    chk({tag, " got_type"}, 32'(b0.reward_got_type), 0);
    chk({tag, " d1 set_require"}, 32'(b1.set_require), 0);
  endtask

  task automatic drive_random(input bit allow_mode);
    int r, x1, y1, x2, y2;
    b0.frame_tick = ($urandom_range(0, 3) == 0);
    if (allow_mode) begin
      r = $urandom_range(0, 199);
      case (r)
        0: begin b0.enable_game_classic = 1'b0; b0.enable_game_infinity = 1'b0; end
        1: begin b0.enable_game_classic = 1'b1; b0.enable_game_infinity = 1'b0; end
        2: begin b0.enable_game_classic = 1'b0; b0.enable_game_infinity = 1'b1; end
        3: begin b0.enable_game_classic = 1'b1; b0.enable_game_infinity = 1'b1; end
        default: ;
      endcase
    end
    x1 = $urandom_range(0, 19); y1 = $urandom_range(0, 19);
    x2 = $urandom_range(0, 19); y2 = $urandom_range(0, 19);
    r = $urandom_range(0, 39);
    if (b0.set_require && (r == 0 || r == 2)) begin
      x1 = int'(b0.random_xpos); y1 = int'(b0.random_ypos);
    end
    if (b0.set_require && (r == 1 || r == 2)) begin
      x2 = int'(b0.random_xpos); y2 = int'(b0.random_ypos);
    end
    if (r >= 3 && r <= 5) begin
      x1 = 0; y1 = 0; x2 = 19; y2 = 19;
    end
    b0.tank1_xpos = 5'(x1); b0.tank1_ypos = 5'(y1);
    b0.tank2_xpos = 5'(x2); b0.tank2_ypos = 5'(y2);
    b1.frame_tick           = b0.frame_tick;
    b1.enable_game_classic  = b0.enable_game_classic;
    b1.enable_game_infinity = b0.enable_game_infinity;
    b1.tank1_xpos = 5'd0;   b1.tank1_ypos = 5'd0;
    b1.tank2_xpos = 5'(x2); b1.tank2_ypos = 5'(y2);
  endtask

  initial begin
    bit seen;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    b0.enable_game_classic = 1'b0; b0.enable_game_infinity = 1'b0; b0.frame_tick = 1'b0;
    b0.tank1_xpos = '0; b0.tank1_ypos = '0; b0.tank2_xpos = 5'd5; b0.tank2_ypos = 5'd5;
    b1.enable_game_classic = 1'b0; b1.enable_game_infinity = 1'b0; b1.frame_tick = 1'b0;
    b1.tank1_xpos = '0; b1.tank1_ypos = '0; b1.tank2_xpos = 5'd5; b1.tank2_ypos = 5'd5;
    repeat (2) @(negedge clk);
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    b0.enable_game_classic = 1'b1;
    b1.enable_game_classic = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      drive_random(1'b1);
      if (i == 2000) begin
        b0.enable_game_classic = 1'b1;
        b1.enable_game_classic = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
          @(negedge clk);
          if (b0.set_require) seen = 1'b1;
          else drive_random(1'b0);
        end
        chk("midshow reset reached SHOW", 32'(seen), 1);
        #2 rst_n = 1'b0;
        #1 check_zero("async reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    end
    @(negedge clk);
    b0.enable_game_classic = 1'b0; b0.enable_game_infinity = 1'b0;
    b1.enable_game_classic = 1'b0; b1.enable_game_infinity = 1'b0;
    repeat (4) @(negedge clk);
    chk("d0 pending events", q0.size(), 0);
    chk("d1 pending events", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
